// File: rtl/alu_pkg.sv
// Opcode and sequencer-state definitions shared by the ALU sharing controller
// and anything that talks to the ALU.
package alu_pkg;

   typedef enum logic [3:0] {
      ADD = 4'b0000,
      SUB = 4'b0001,
      AND = 4'b0010,
      ORR = 4'b0011,
      XOR = 4'b0100,
      NOT = 4'b0101,
      LSA = 4'b0110,
      RSA = 4'b0111,
      LSL = 4'b1000,
      RSL = 4'b1001,
      DIV = 4'b1010
   } alu_op_t;

   localparam logic [3:0] OP_LAST = 4'b1010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } ctrl_state_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      return op <= OP_LAST;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by prio. Grant is one-hot or zero.
module rr_arb2 (
   input  logic [1:0] req_valid,
   input  logic       prio,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (req_valid == 2'b11) begin
         grant = prio ? 2'b10 : 2'b01;
      end else begin
         grant = req_valid;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters: round-robin accept,
// registered operands for a fixed settle time, then a held response.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int N           = 32,
   parameter int EXEC_CYCLES = 1,
   parameter int DIV_CYCLES  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [1:0][N-1:0]   req_a,
   input  logic [1:0][N-1:0]   req_b,
   input  logic [1:0][3:0]     req_op,
   output logic [1:0]          rsp_valid,
   input  logic [1:0]          rsp_ready,
   output logic [N-1:0]        rsp_result,
   output logic [3:0]          rsp_flags,
   output logic                rsp_err,
   output logic [N-1:0]        alu_a,
   output logic [N-1:0]        alu_b,
   output logic [3:0]          alu_ctrl,
   input  logic [N-1:0]        alu_result,
   input  logic [3:0]          alu_flags
);

   localparam int MAX_CYCLES = (DIV_CYCLES > EXEC_CYCLES) ? DIV_CYCLES : EXEC_CYCLES;
   localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

   ctrl_state_t      state_q, state_d;
   logic             prio_q, prio_d;
   logic             owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     a_q, a_d;
   logic [N-1:0]     b_q, b_d;
   logic [3:0]       ctrl_q, ctrl_d;
   logic             ill_q, ill_d;
   logic [N-1:0]     result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;

   logic [1:0]       grant;
   logic             sel;
   logic [3:0]       op_sel;

   rr_arb2 u_arb (
      .req_valid (req_valid),
      .prio      (prio_q),
      .grant     (grant)
   );

   assign sel    = grant[1];
   assign op_sel = req_op[sel];

   always_comb begin
      req_ready = 2'b00;
      if (rst_n && state_q == IDLE) begin
         req_ready = grant;
      end
   end

   always_comb begin
      state_d  = state_q;
      prio_d   = prio_q;
      owner_d  = owner_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      ctrl_d   = ctrl_q;
      ill_d    = ill_q;
      result_d = result_q;
      flags_d  = flags_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               owner_d = sel;
               a_d     = req_a[sel];
               b_d     = req_b[sel];
               state_d = EXEC;
               // Illegal codes still run one settle cycle, but the ALU sees ADD
               if (!op_is_legal(op_sel)) begin
                  ill_d  = 1'b1;
                  ctrl_d = ADD;
                  cnt_d  = '0;
               end else begin
                  ill_d  = 1'b0;
                  ctrl_d = op_sel;
                  cnt_d  = (op_sel == DIV) ? DIV_LOAD : EXEC_LOAD;
               end
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               result_d = ill_q ? '0 : alu_result;
               flags_d  = ill_q ? 4'b0000 : alu_flags;
               err_d    = ill_q;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_ready[owner_q]) begin
               prio_d  = ~owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         owner_q  <= 1'b0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= 4'b0000;
         ill_q    <= 1'b0;
         result_q <= '0;
         flags_q  <= 4'b0000;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         owner_q  <= owner_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ctrl_q   <= ctrl_d;
         ill_q    <= ill_d;
         result_q <= result_d;
         flags_q  <= flags_d;
         err_q    <= err_d;
      end
   end

   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_ctrl   = ctrl_q;
   assign rsp_result = result_q;
   assign rsp_flags  = flags_q;
   assign rsp_err    = err_q;
   assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares the single combinational `ALU_N_bits` instance between two requesters, for example the CPU execute stage and the 2D graphics engine. It accepts one operation at a time through a valid/ready handshake and picks between requesters round-robin. It drives the ALU operands and opcode from registers, waits a fixed number of settle cycles (longer for DIV), then captures result and flags. The response goes back to the owning requester with its own valid/ready handshake.

## Interface
Parameters:
- `N`, default 32: operand/result width; must match the ALU instance.
- `EXEC_CYCLES`, default 1: settle cycles for opcodes 0000–1001; minimum 1.
- `DIV_CYCLES`, default 4: settle cycles for DIV (1010); minimum 1.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `req_valid`, in, [1:0]: request valid, per requester i.
- `req_ready`, out, [1:0]: request accepted, per requester.
- `req_a`, in, [1:0][N-1:0]: operand A, per requester.
- `req_b`, in, [1:0][N-1:0]: operand B, per requester.
- `req_op`, in, [1:0][3:0]: ALUControl code, per requester.
- `rsp_valid`, out, [1:0]: response valid, per requester.
- `rsp_ready`, in, [1:0]: response consumed, per requester.
- `rsp_result`, out, N: captured result, shared bus.
- `rsp_flags`, out, 4: captured ALU flags, shared bus.
- `rsp_err`, out, 1: set when the opcode is illegal.
- `alu_a`, out, N: ALU operand A.
- `alu_b`, out, N: ALU operand B.
- `alu_ctrl`, out, 4: ALU opcode.
- `alu_result`, in, N: ALU result.
- `alu_flags`, in, 4: ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - The arbiter picks a winner among the asserted `req_valid` bits.
  - Priority pointer `prio` (1 bit) names the favoured requester. When only one request is valid, that requester wins.
  - `req_ready[winner]` = 1 combinationally, and only in IDLE. At most one `req_ready` bit is high.
  - On the handshake (`req_valid[w] & req_ready[w]`): latch a, b, op and owner `w` into registers, load the settle counter, go to EXEC.
- **EXEC**
  - `alu_a`, `alu_b` and `alu_ctrl` come from the latched registers and are stable for the whole state.
  - Counter load value: `DIV_CYCLES-1` for op 1010, otherwise `EXEC_CYCLES-1`. The counter decrements each cycle.
  - At 0: capture `alu_result` and `alu_flags` into the response registers, go to RESP.
- **Illegal opcode (1011–1111)**
  - The op is still accepted.
  - `alu_ctrl` is driven 0000 (ADD); the ALU output is ignored.
  - Settle time is 1 cycle. Response: result 0, flags 0, `rsp_err` = 1.
- **RESP**
  - `rsp_valid[owner]` = 1; the other bit is 0.
  - Result, flags and err are held until `rsp_ready[owner]`.
  - On the handshake: `prio` = ~owner, go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- Requests arriving during EXEC or RESP wait; their `req_ready` stays 0.
- Requesters must hold a, b and op stable while `req_valid` is high and unaccepted. The controller does not check this.
- **Reset** (`rst_n` = 0 at an edge)
  - state IDLE, `prio` 0, counter 0.
  - All `rsp_valid` 0, `rsp_result` 0, `rsp_flags` 0, `rsp_err` 0.
  - `alu_a`/`alu_b`/`alu_ctrl` registers 0.
  - An in-flight op is dropped with no response.
  - `req_ready` = 0 while `rst_n` is low.

## Timing
- Accept at edge T → EXEC during T+1 … T+k, where k = settle cycles → RESP from T+k+1.
- Default non-DIV latency: 2 cycles from acceptance to `rsp_valid`. DIV default: 5.
- Minimum issue interval: k+2 cycles (EXEC, RESP with immediate ready, IDLE).
- No back-to-back issue: IDLE always lasts at least one cycle after RESP.
- The first request after reset with both valid is granted to requester 0.
- Simultaneous `req_valid` = 2'b11 grants alternate 0, 1, 0, 1.
- `rsp_valid` held for N cycles of backpressure keeps the data constant and blocks all new acceptance.
- `rsp_ready` high before `rsp_valid` is allowed. The transfer completes on the first RESP cycle.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` enum: ADD 0000, SUB 0001, AND 0010, ORR 0011, XOR 0100, NOT 0101, LSA 0110, RSA 0111, LSL 1000, RSL 1001, DIV 1010.
  - `OP_LAST` = 4'b1010.
  - `ctrl_state_t` enum {IDLE, EXEC, RESP}.
- Sub-module `rr_arb2`: 2-way round-robin grant, combinational from `req_valid` and `prio`, producing a one-hot grant.
- The ALU is instantiated outside this block, at the level that also connects the requesters.

## Test plan
- **Single ADD.** Req0: a=4, b=2, op 0000, `rsp_ready` held 1 → `rsp_valid[0]` 2 cycles after acceptance, result 6, `rsp_err` 0. `req_ready` 0 throughout EXEC and RESP.
- **Contention.** Both requesters valid continuously: req0 SUB 4,2 and req1 AND 4,2 → grants in order 0, 1, 0, 1. Results alternate 2 and 0. Issue every 3 cycles.
- **DIV stretch.** Req1: a=8, b=2, op 1010 → `alu_ctrl` holds 1010 for exactly 4 cycles, result 4, `rsp_valid[1]` 5 cycles after acceptance.
- **Backpressure.** Req0 RSA a=4'b1100 b=2 with `rsp_ready[0]` = 0 for 6 cycles, while req1 is valid → response stable for all 6 cycles. Req1 is accepted only in the IDLE cycle after the handshake.
- **Illegal opcode.** Req0 op 1111 → `alu_ctrl` 0000, response result 0, flags 0, `rsp_err` 1, latency 2.
- **Reset mid-op.** Accept a DIV, then assert `rst_n` = 0 in the 2nd EXEC cycle for 1 cycle → no `rsp_valid`. All outputs are 0 the cycle after. The next simultaneous request is granted to requester 0.
